// File: rtl/wb_snoop_arbiter.sv
// wb_snoop_arbiter: two-master Wishbone arbiter with round-robin grant and
// a one-cycle snoop broadcast of every completed write toward both caches.
// Optional bus timeout is compiled in with the macro WB_ARB_TIMEOUT_EN; without
// it the arbiter waits indefinitely for s_ack and the err outputs are tied low.
module wb_snoop_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_cyc,
    input  logic                  m0_stb,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_adr,
    input  logic [31:0]           m0_dat_w,
    input  logic [3:0]            m0_sel,
    output logic                  m0_ack,
    output logic                  m0_err,
    output logic [31:0]           m0_dat_r,
    input  logic                  m1_cyc,
    input  logic                  m1_stb,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_adr,
    input  logic [31:0]           m1_dat_w,
    input  logic [3:0]            m1_sel,
    output logic                  m1_ack,
    output logic                  m1_err,
    output logic [31:0]           m1_dat_r,
    output logic                  s_cyc,
    output logic                  s_stb,
    output logic                  s_we,
    output logic [ADDR_WIDTH-1:0] s_adr,
    output logic [31:0]           s_dat_w,
    output logic [3:0]            s_sel,
    input  logic                  s_ack,
    input  logic [31:0]           s_dat_r,
    output logic                  snoop_valid,
    output logic [ADDR_WIDTH-1:0] snoop_addr,
    output logic                  snoop_src
);

    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_range
        $error("wb_snoop_arbiter: TIMEOUT must be within 1..255");
    end

`ifdef WB_ARB_TIMEOUT_EN
    typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, ERROR = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1} state_t;
`endif

    state_t                state_q, state_d;
    logic                  grant_q, grant_d;
    logic                  last_grant_q, last_grant_d;
    logic                  snoop_valid_q, snoop_valid_d;
    logic [ADDR_WIDTH-1:0] snoop_addr_q, snoop_addr_d;
    logic                  snoop_src_q, snoop_src_d;
`ifdef WB_ARB_TIMEOUT_EN
    logic [7:0]            tmo_cnt_q, tmo_cnt_d;
`endif

    logic                  gnt_cyc;
    logic                  gnt_live;

    // Granted master's own cycle line decides when the bus is released.
    assign gnt_cyc = grant_q ? m1_cyc : m0_cyc;
    // Reset low suppresses every bus-facing handshake in the same cycle.
    assign gnt_live = rst && (state_q == GRANT);

    // Next-state: arbitration in IDLE, release/snoop/timeout tracking in GRANT.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_grant_d  = last_grant_q;
        snoop_valid_d = 1'b0;
        snoop_addr_d  = snoop_addr_q;
        snoop_src_d   = snoop_src_q;
`ifdef WB_ARB_TIMEOUT_EN
        tmo_cnt_d     = tmo_cnt_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef WB_ARB_TIMEOUT_EN
                tmo_cnt_d = 8'd0;
`endif
                if (m0_cyc && m1_cyc) begin
                    grant_d      = ~last_grant_q;
                    last_grant_d = ~last_grant_q;
                    state_d      = GRANT;
                end else if (m0_cyc) begin
                    grant_d      = 1'b0;
                    last_grant_d = 1'b0;
                    state_d      = GRANT;
                end else if (m1_cyc) begin
                    grant_d      = 1'b1;
                    last_grant_d = 1'b1;
                    state_d      = GRANT;
                end
            end
            GRANT: begin
                if (s_ack && s_stb && s_we) begin
                    snoop_valid_d = 1'b1;
                    snoop_addr_d  = s_adr;
                    snoop_src_d   = grant_q;
                end
                if (!gnt_cyc) begin
                    state_d = IDLE;
`ifdef WB_ARB_TIMEOUT_EN
                    tmo_cnt_d = 8'd0;
                end else if (s_ack) begin
                    tmo_cnt_d = 8'd0;
                end else if (s_stb) begin
                    if (tmo_cnt_q == 8'(TIMEOUT - 1)) begin
                        state_d   = ERROR;
                        tmo_cnt_d = 8'd0;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + 8'd1;
                    end
`endif
                end
            end
`ifdef WB_ARB_TIMEOUT_EN
            ERROR: begin
                state_d = IDLE;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and snoop registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= IDLE;
            grant_q       <= 1'b0;
            last_grant_q  <= 1'b1;
            snoop_valid_q <= 1'b0;
            snoop_addr_q  <= '0;
            snoop_src_q   <= 1'b0;
`ifdef WB_ARB_TIMEOUT_EN
            tmo_cnt_q     <= 8'd0;
`endif
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_grant_q  <= last_grant_d;
            snoop_valid_q <= snoop_valid_d;
            snoop_addr_q  <= snoop_addr_d;
            snoop_src_q   <= snoop_src_d;
`ifdef WB_ARB_TIMEOUT_EN
            tmo_cnt_q     <= tmo_cnt_d;
`endif
        end
    end

    // Bus mux: slave side mirrors the granted master, responses go back only to it.
    always_comb begin
        s_cyc    = gnt_live && gnt_cyc;
        s_stb    = gnt_live && (grant_q ? m1_stb : m0_stb);
        s_we     = grant_q ? m1_we : m0_we;
        s_adr    = grant_q ? m1_adr : m0_adr;
        s_dat_w  = grant_q ? m1_dat_w : m0_dat_w;
        s_sel    = grant_q ? m1_sel : m0_sel;
        m0_ack   = gnt_live && !grant_q && s_ack;
        m1_ack   = gnt_live && grant_q && s_ack;
        m0_dat_r = (gnt_live && !grant_q) ? s_dat_r : 32'd0;
        m1_dat_r = (gnt_live && grant_q) ? s_dat_r : 32'd0;
`ifdef WB_ARB_TIMEOUT_EN
        m0_err   = rst && (state_q == ERROR) && !grant_q;
        m1_err   = rst && (state_q == ERROR) && grant_q;
`else
        m0_err   = 1'b0;
        m1_err   = 1'b0;
`endif
    end

    assign snoop_valid = snoop_valid_q;
    assign snoop_addr  = snoop_addr_q;
    assign snoop_src   = snoop_src_q;

endmodule

// File: tb/tb_wb_snoop_arbiter.sv
// Testbench for wb_snoop_arbiter: directed scenarios with literal expectations,
// then randomized master/memory traffic compared every cycle against a
// transaction-level model of grant ownership, snoop pulses and bus timeout.
module tb_wb_snoop_arbiter;

    localparam int AW         = 32;
    localparam int TB_TIMEOUT = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            m0_cyc = 1'b0, m0_stb = 1'b0, m0_we = 1'b0;
    logic [AW-1:0]   m0_adr = '0;
    logic [31:0]     m0_dat_w = '0;
    logic [3:0]      m0_sel = '0;
    logic            m0_ack, m0_err;
    logic [31:0]     m0_dat_r;
    logic            m1_cyc = 1'b0, m1_stb = 1'b0, m1_we = 1'b0;
    logic [AW-1:0]   m1_adr = '0;
    logic [31:0]     m1_dat_w = '0;
    logic [3:0]      m1_sel = '0;
    logic            m1_ack, m1_err;
    logic [31:0]     m1_dat_r;
    logic            s_cyc, s_stb, s_we;
    logic [AW-1:0]   s_adr;
    logic [31:0]     s_dat_w;
    logic [3:0]      s_sel;
    logic            s_ack = 1'b0;
    logic [31:0]     s_dat_r = '0;
    logic            snoop_valid;
    logic [AW-1:0]   snoop_addr;
    logic            snoop_src;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: who owns the bus (-1 = nobody), pending error, fairness, stall time.
    int              mdl_owner   = -1;
    bit              mdl_err     = 1'b0;
    int              mdl_err_who = 0;
    int              mdl_last    = 1;
    int              mdl_stall   = 0;
    bit              mdl_sv      = 1'b0;
    logic [AW-1:0]   mdl_sa      = '0;
    int              mdl_ss      = 0;

    wb_snoop_arbiter #(.ADDR_WIDTH(AW), .TIMEOUT(TB_TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
        .m0_dat_w(m0_dat_w), .m0_sel(m0_sel), .m0_ack(m0_ack), .m0_err(m0_err),
        .m0_dat_r(m0_dat_r),
        .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
        .m1_dat_w(m1_dat_w), .m1_sel(m1_sel), .m1_ack(m1_ack), .m1_err(m1_err),
        .m1_dat_r(m1_dat_r),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
        .s_dat_w(s_dat_w), .s_sel(s_sel), .s_ack(s_ack), .s_dat_r(s_dat_r),
        .snoop_valid(snoop_valid), .snoop_addr(snoop_addr), .snoop_src(snoop_src)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, actual, expected, $time);
        end
    endtask

    // Inputs change one time unit after the rising edge.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic nextMaster(input logic done, inout logic cyc, inout logic stb,
                              inout logic we, inout logic [AW-1:0] adr,
                              inout logic [31:0] dat, inout logic [3:0] sel);
        logic start;
        start = 1'b0;
        if (cyc && done) begin
            if ($urandom_range(0, 1) == 0) begin
                cyc = 1'b0;
                stb = 1'b0;
            end else begin
                start = 1'b1;
            end
        end else if (!cyc && $urandom_range(0, 2) == 0) begin
            start = 1'b1;
        end
        if (start) begin
            cyc = 1'b1;
            stb = 1'b1;
            we  = 1'($urandom_range(0, 1));
            adr = AW'({$urandom_range(0, 255), 2'b00});
            dat = $urandom;
            sel = 4'($urandom_range(1, 15));
        end
    endtask

    // Per-cycle compare against the model, then advance the model across the next edge.
    always @(negedge clk) begin : cmp
        logic          mc [2];
        logic          ms [2];
        logic          mw [2];
        logic [AW-1:0] ma [2];
        logic [31:0]   md [2];
        logic [3:0]    mb [2];
        logic          e_ack [2];
        logic          e_err [2];
        logic [31:0]   e_dat [2];
        logic          e_cyc, e_stb, nsv;
        int            o;

        mc[0] = m0_cyc; ms[0] = m0_stb; mw[0] = m0_we; ma[0] = m0_adr; md[0] = m0_dat_w; mb[0] = m0_sel;
        mc[1] = m1_cyc; ms[1] = m1_stb; mw[1] = m1_we; ma[1] = m1_adr; md[1] = m1_dat_w; mb[1] = m1_sel;
        e_ack[0] = 1'b0; e_ack[1] = 1'b0;
        e_err[0] = 1'b0; e_err[1] = 1'b0;
        e_dat[0] = '0;   e_dat[1] = '0;
        e_cyc = 1'b0;
        e_stb = 1'b0;
        o = mdl_owner;

        if (rst) begin
            if (mdl_err) begin
                e_err[mdl_err_who] = 1'b1;
            end else if (o >= 0) begin
                e_cyc    = mc[o];
                e_stb    = ms[o];
                e_ack[o] = s_ack;
                e_dat[o] = s_dat_r;
            end
        end

        checkOutput("m0_ack", m0_ack, e_ack[0]);
        checkOutput("m1_ack", m1_ack, e_ack[1]);
        checkOutput("m0_err", m0_err, e_err[0]);
        checkOutput("m1_err", m1_err, e_err[1]);
        checkOutput("m0_dat_r", m0_dat_r, e_dat[0]);
        checkOutput("m1_dat_r", m1_dat_r, e_dat[1]);
        checkOutput("s_cyc", s_cyc, e_cyc);
        checkOutput("s_stb", s_stb, e_stb);
        if (e_cyc) begin
            checkOutput("s_we", s_we, mw[o]);
            checkOutput("s_adr", s_adr, ma[o]);
            checkOutput("s_dat_w", s_dat_w, md[o]);
            checkOutput("s_sel", s_sel, mb[o]);
        end
        checkOutput("snoop_valid", snoop_valid, mdl_sv);
        checkOutput("snoop_addr", snoop_addr, mdl_sa);
        checkOutput("snoop_src", snoop_src, mdl_ss);

        if (!rst) begin
            mdl_owner = -1; mdl_err = 1'b0; mdl_last = 1; mdl_stall = 0;
            mdl_sv = 1'b0; mdl_sa = '0; mdl_ss = 0;
        end else begin
            nsv = 1'b0;
            if (mdl_err) begin
                mdl_err   = 1'b0;
                mdl_owner = -1;
            end else if (o < 0) begin
                mdl_stall = 0;
                if (mc[0] && mc[1]) mdl_owner = 1 - mdl_last;
                else if (mc[0])     mdl_owner = 0;
                else if (mc[1])     mdl_owner = 1;
                if (mdl_owner >= 0) mdl_last = mdl_owner;
            end else begin
                if (s_ack && ms[o] && mw[o]) begin
                    nsv = 1'b1; mdl_sa = ma[o]; mdl_ss = o;
                end
                if (!mc[o]) begin
                    mdl_owner = -1;
                    mdl_stall = 0;
                end else if (s_ack) begin
                    mdl_stall = 0;
                end else if (ms[o]) begin
                    mdl_stall++;
`ifdef WB_ARB_TIMEOUT_EN
                    if (mdl_stall == TB_TIMEOUT) begin
                        mdl_err = 1'b1; mdl_err_who = o; mdl_owner = -1; mdl_stall = 0;
                    end
`endif
                end
            end
            mdl_sv = nsv;
        end
    end

    initial begin : stim
        logic done0, done1;

        // Reset: everything idle, snoop registers cleared.
        rst = 1'b0;
        repeat (3) applyStimulus();
        @(negedge clk);
        checkOutput("rst_s_cyc", s_cyc, 0);
        checkOutput("rst_snoop_valid", snoop_valid, 0);
        checkOutput("rst_snoop_addr", snoop_addr, 0);
        checkOutput("rst_m0_ack", m0_ack, 0);
        applyStimulus(); rst = 1'b1;

        // Single m0 write, ack two cycles into the grant, then snoop pulse.
        applyStimulus(); m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_adr = 32'h100; m0_dat_w = 32'h11223344; m0_sel = 4'hF;
        @(negedge clk); checkOutput("t1_decision_s_cyc", s_cyc, 0);
        applyStimulus();
        @(negedge clk); checkOutput("t1_grant_s_cyc", s_cyc, 1); checkOutput("t1_s_adr", s_adr, 32'h100);
        applyStimulus();
        @(negedge clk); checkOutput("t1_wait_m0_ack", m0_ack, 0);
        applyStimulus(); s_ack = 1;
        @(negedge clk); checkOutput("t1_m0_ack", m0_ack, 1); checkOutput("t1_m1_ack", m1_ack, 0);
        checkOutput("t1_no_early_snoop", snoop_valid, 0);
        applyStimulus(); s_ack = 0; m0_cyc = 0; m0_stb = 0;
        @(negedge clk); checkOutput("t1_snoop_valid", snoop_valid, 1);
        checkOutput("t1_snoop_addr", snoop_addr, 32'h100); checkOutput("t1_snoop_src", snoop_src, 0);
        applyStimulus();
        @(negedge clk); checkOutput("t1_snoop_once", snoop_valid, 0);

        // Second reset restores last_grant so simultaneous requests favour m0.
        applyStimulus(); rst = 1'b0;
        applyStimulus(); rst = 1'b1;
        applyStimulus();
        m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_adr = 32'h40; m0_dat_w = 32'hA5A5A5A5;
        m1_cyc = 1; m1_stb = 1; m1_we = 0; m1_adr = 32'h200;
        @(negedge clk); checkOutput("t2_decision_s_cyc", s_cyc, 0);
        applyStimulus(); s_ack = 1;
        @(negedge clk); checkOutput("t2_m0_first_adr", s_adr, 32'h40);
        checkOutput("t2_m0_ack", m0_ack, 1); checkOutput("t2_m1_stalled", m1_ack, 0);
        applyStimulus(); s_ack = 0; m0_cyc = 0; m0_stb = 0;
        @(negedge clk); checkOutput("t2_release_s_cyc", s_cyc, 0);
        checkOutput("t2_snoop_addr", snoop_addr, 32'h40); checkOutput("t2_m1_still_stalled", m1_ack, 0);
        applyStimulus();
        @(negedge clk); checkOutput("t2_idle_gap_s_cyc", s_cyc, 0);
        applyStimulus(); s_ack = 1; s_dat_r = 32'hDEADBEEF;
        @(negedge clk); checkOutput("t2_m1_adr", s_adr, 32'h200);
        checkOutput("t2_m1_ack", m1_ack, 1); checkOutput("t2_m1_dat_r", m1_dat_r, 32'hDEADBEEF);
        checkOutput("t2_m0_ack", m0_ack, 0); checkOutput("t2_m0_dat_r", m0_dat_r, 0);
        applyStimulus(); s_ack = 0; s_dat_r = 0; m1_cyc = 0; m1_stb = 0;
        @(negedge clk); checkOutput("t2_read_no_snoop", snoop_valid, 0);

        // Three back-to-back write acks from m0.
        applyStimulus(); m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_adr = 32'h10;
        @(negedge clk); checkOutput("t3_decision_s_cyc", s_cyc, 0);
        applyStimulus(); s_ack = 1;
        @(negedge clk); checkOutput("t3_ack0", m0_ack, 1);
        applyStimulus(); m0_adr = 32'h14;
        @(negedge clk); checkOutput("t3_sv0", snoop_valid, 1); checkOutput("t3_sa0", snoop_addr, 32'h10);
        applyStimulus(); m0_adr = 32'h18;
        @(negedge clk); checkOutput("t3_sv1", snoop_valid, 1); checkOutput("t3_sa1", snoop_addr, 32'h14);
        applyStimulus(); s_ack = 0; m0_cyc = 0; m0_stb = 0;
        @(negedge clk); checkOutput("t3_sv2", snoop_valid, 1); checkOutput("t3_sa2", snoop_addr, 32'h18);
        applyStimulus();
        @(negedge clk); checkOutput("t3_sv_end", snoop_valid, 0);

        // Reset arrives together with a write ack: the ack is dropped.
        applyStimulus(); m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_adr = 32'h300;
        applyStimulus();
        @(negedge clk); checkOutput("t4_granted", s_cyc, 1);
        applyStimulus(); rst = 1'b0; s_ack = 1;
        @(negedge clk); checkOutput("t4_rst_m0_ack", m0_ack, 0);
        applyStimulus(); rst = 1'b1; s_ack = 0;
        @(negedge clk); checkOutput("t4_s_cyc_after", s_cyc, 0);
        checkOutput("t4_no_snoop", snoop_valid, 0); checkOutput("t4_m0_ack_after", m0_ack, 0);
        applyStimulus(); m0_cyc = 0; m0_stb = 0;
        applyStimulus();

`ifdef WB_ARB_TIMEOUT_EN
        // m1 write never acked: error pulse TB_TIMEOUT cycles after the stall begins.
        applyStimulus(); m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_adr = 32'h500;
        applyStimulus();
        repeat (TB_TIMEOUT - 1) applyStimulus();
        @(negedge clk); checkOutput("t5_no_err_yet", m1_err, 0);
        applyStimulus();
        @(negedge clk); checkOutput("t5_m1_err", m1_err, 1); checkOutput("t5_s_cyc", s_cyc, 0);
        checkOutput("t5_m0_err", m0_err, 0);
        applyStimulus(); m1_cyc = 0; m1_stb = 0;
        @(negedge clk); checkOutput("t5_err_once", m1_err, 0); checkOutput("t5_idle_s_cyc", s_cyc, 0);
        applyStimulus();
`endif

        // Randomized traffic with occasional reset pulses.
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            done0 = m0_ack || m0_err;
            done1 = m1_ack || m1_err;
            applyStimulus();
            rst     = ($urandom_range(0, 99) != 0);
            s_ack   = 1'($urandom_range(0, 1));
            s_dat_r = $urandom;
            nextMaster(done0, m0_cyc, m0_stb, m0_we, m0_adr, m0_dat_w, m0_sel);
            nextMaster(done1, m1_cyc, m1_stb, m1_we, m1_adr, m1_dat_w, m1_sel);
        end
        @(negedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_snoop_arbiter.md
WB_SNOOP_ARBITER -- requirements
Module: wb_snoop_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, Wishbone address width.
REQ-002 SHALL have parameter TIMEOUT, default 255, maximum stalled cycles before a bus error (range 1..255).
REQ-003 SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1, reset, synchronous, active-low.
REQ-005 SHALL have ports m0_cyc, m0_stb, m0_we, inputs, 1 each, master 0 (cache 0) Wishbone cycle, strobe and write.
REQ-006 SHALL have ports m0_adr (ADDR_WIDTH), m0_dat_w (32) and m0_sel (4), inputs, master 0 address, write data and byte selects.
REQ-007 SHALL have ports m0_ack (1), m0_err (1) and m0_dat_r (32), outputs, master 0 acknowledge, error and read data.
REQ-008 SHALL have m1_* ports identical to REQ-005..007 for master 1 (cache 1).
REQ-009 SHALL have ports s_cyc, s_stb, s_we (1 each), s_adr (ADDR_WIDTH), s_dat_w (32) and s_sel (4), outputs, toward memory.
REQ-010 SHALL have ports s_ack (1) and s_dat_r (32), inputs, memory acknowledge and read data.
REQ-011 SHALL have ports snoop_valid (1), snoop_addr (ADDR_WIDTH) and snoop_src (1), outputs, broadcast of completed writes to the caches.

Function
REQ-012 SHALL implement FSM states IDLE, GRANT, ERROR.
REQ-013 In IDLE, when either mN_cyc is high, SHALL register the winner, enter GRANT next cycle and drive no slave signals during the decision cycle.
REQ-014 When both mN_cyc are high in IDLE, SHALL grant the master not granted last (round-robin); last_grant resets to 1, so master 0 wins first.
REQ-015 In GRANT, s_cyc/s_stb/s_we/s_adr/s_dat_w/s_sel SHALL combinationally mirror the granted master; otherwise s_cyc=s_stb=0.
REQ-016 s_ack and s_dat_r SHALL route only to the granted master; the other master's ack/err SHALL be 0 and its dat_r 0.
REQ-017 SHALL leave GRANT for IDLE in the cycle after the granted master samples cyc low, giving at least one idle cycle between grants.
REQ-018 A requesting master that loses arbitration SHALL stay stalled (ack=0) until granted.
REQ-019 On each cycle with s_ack=1, s_stb=1 and s_we=1 in GRANT, SHALL, on the next cycle, pulse snoop_valid for exactly 1 cycle with snoop_addr=s_adr and snoop_src=granted id.
REQ-020 Read completions SHALL NOT generate snoop_valid.
REQ-021 Back-to-back write acks SHALL produce back-to-back snoop_valid pulses, one per ack.

Reset
REQ-022 While rst=0, at the next edge SHALL set state=IDLE, last_grant=1, timeout counter=0, snoop_valid=0, snoop_addr=0, snoop_src=0.
REQ-023 All master ack/err outputs and s_cyc/s_stb SHALL be 0 from the first edge with rst=0, aborting any in-flight transfer; an s_ack arriving then SHALL be discarded.

Configuration
REQ-024 Macro WB_ARB_TIMEOUT_EN SHALL gate the bus timeout.
REQ-025 With WB_ARB_TIMEOUT_EN defined, an 8-bit counter SHALL count GRANT cycles with s_stb=1 and s_ack=0, clear on any ack or grant change, and on reaching TIMEOUT enter ERROR.
REQ-026 ERROR SHALL drive s_cyc=0, assert mN_err to the granted master for exactly 1 cycle, then return to IDLE with last_grant updated.
REQ-027 Without WB_ARB_TIMEOUT_EN, SHALL omit the counter and ERROR state, tie m0_err and m1_err to 0, and wait indefinitely for s_ack.

Verification
REQ-028 Reset, then m0 write adr=0x100 with s_ack after 2 cycles -> m0_ack 1 cycle; next cycle snoop_valid=1, snoop_addr=0x100, snoop_src=0.
REQ-029 m0 and m1 raise cyc in the same cycle -> m0 granted first; after m0 drops cyc, one idle cycle, then m1 granted.
REQ-030 m1 read adr=0x200, s_dat_r=0xDEADBEEF -> m1_dat_r=0xDEADBEEF with m1_ack; m0_ack=0; snoop_valid stays 0.
REQ-031 m0 performs 3 back-to-back single-cycle write acks at 0x10, 0x14, 0x18 -> 3 consecutive snoop_valid pulses with those addresses.
REQ-032 WB_ARB_TIMEOUT_EN, TIMEOUT=4, m1 write with no s_ack -> m1_err=1 for 1 cycle 4 cycles after stall start, s_cyc=0, FSM back in IDLE.
REQ-033 rst=0 asserted mid-write with s_ack in the same cycle -> no mN_ack, no snoop_valid, s_cyc=0 next cycle.
